rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Round-robin arbiter: the serving end of a merged request line. Requesters
//  OR their requests together; this block decides which single requester owns
//  the shared resource. It issues a one-hot grant, holds it until release, then
//  rotates priority so every requester is served fairly.
// PARAMETERS
//  N        4   number of requesters (2..16)
//  IDW      2   width of gnt_id; must equal clog2(N)
//  TIMEOUT  16  grant watchdog limit in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  req        in   N    request vector, bit i = requester i
//  done       in   1    release strobe from the current grant owner
//  gnt        out  N    one-hot grant, all zero when idle
//  gnt_valid  out  1    1 while any grant is held (OR of gnt)
//  gnt_id     out  IDW  binary index of the granted requester
//  timeout    out  1    one-cycle pulse on a watchdog release
// BEHAVIOUR
//  - Reset, async on rst_n=0, takes effect immediately:
//    gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0, state=IDLE.
//  - ptr (IDW bits) is the highest-priority index. The search order is
//    ptr, ptr+1, ... N-1, 0, ... ptr-1.
//  - FSM IDLE:
//    - if |req, grant the first set bit in search order; go to GRANT.
//    - gnt, gnt_valid and gnt_id are registered and appear the cycle after
//      req is sampled (latency 1).
//    - if req=0, stay in IDLE with outputs at zero.
//  - FSM GRANT: hold gnt and gnt_id stable. Release at the clock edge where
//    done=1, or req[gnt_id]=0 (owner withdrew), or the watchdog expires.
//    - done while in IDLE is ignored.
//  - On release:
//    - state=IDLE and gnt=0 on the next cycle.
//    - ptr = gnt_id+1, wrapping N-1 -> 0. For non-power-of-two N, wrap
//      explicitly at N.
//  - One IDLE cycle always separates two grants. Minimum spacing between
//    grants is 2 cycles.
//  - Requests from other requesters during GRANT are not granted. They are
//    arbitrated in the first IDLE cycle after release.
//  - If done and a req drop happen together, the result is a single release;
//    ptr is updated once.
//  - req bits at index >= N do not exist; gnt is never multi-hot.
//  - Reset mid-grant drops gnt asynchronously. After reset, priority restarts
//    at requester 0.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - an 8-bit hold counter clears on grant and increments each GRANT cycle.
//    - when the counter reaches TIMEOUT-1 with no other release, force a
//      release and pulse timeout=1 for 1 cycle, aligned with the first IDLE
//      cycle.
//    - ptr advances as for a normal release.
//  - ARB_TIMEOUT_EN undefined:
//    - no counter is built and timeout is tied to 0.
//    - a grant is held indefinitely until done or a req drop.
// TESTING (N=4)
//  1. rst_n=0 mid-grant -> gnt=0000, gnt_valid=0, gnt_id=0 with no clock edge.
//     After rst_n=1 and req=1000, gnt=1000 one cycle later.
//  2. req=0110 at cycle t -> gnt=0010, gnt_id=1 at t+1.
//     done at t+2 -> gnt=0000 at t+3, then gnt=0100, gnt_id=2 at t+4.
//  3. req=1111 held, done on each grant -> gnt_id sequence 0,1,2,3,0,1.
//     Grants at every 2nd cycle minimum.
//  4. Wrap: last grant id=3, then req=1001 -> id=0 granted, not id=3.
//     Next req=1001 -> id=3.
//  5. Owner drop: gnt=0001, req goes 0011->0010 -> release next edge,
//     then gnt=0010; timeout stays 0.
//  6. ARB_TIMEOUT_EN, TIMEOUT=4: req=0001 held, done=0 -> gnt high for
//     exactly 4 cycles, then timeout pulse=1 with gnt=0000.
//     Without the macro, gnt stays 0001 for >100 cycles.

Source files
------------

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Round-robin arbiter with registered one-hot grant; optional  |
// |               grant watchdog enabled by defining ARB_TIMEOUT_EN.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         r_state, w_state_nx;
    logic [N-1:0]   r_gnt, w_gnt_nx;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_nx;
    logic [IDW-1:0] r_ptr, w_ptr_nx;
    logic           r_timeout, w_timeout_nx;

    logic           w_found;
    logic [IDW-1:0] w_pick;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_expire;
    logic [IDW-1:0] w_ptr_after;
    logic           w_release;

    // Walk the requesters starting at r_ptr, wrapping explicitly at N so
    // non-power-of-two sizes never select a nonexistent index.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(TIMEOUT - 1);

    logic [7:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_expire = (r_state == ST_GRANT) && (r_hold_cnt == c_hold_last);
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_expire         = 1'b0;
`endif

    assign w_ptr_after = (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + IDW'(1);
    assign w_release   = done || !req[r_gnt_id] || w_expire;

    always_comb begin
        w_state_nx   = r_state;
        w_gnt_nx     = r_gnt;
        w_gnt_id_nx  = r_gnt_id;
        w_ptr_nx     = r_ptr;
        w_timeout_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nx    = '0;
                w_gnt_id_nx = '0;
                if (w_found) begin
                    w_state_nx          = ST_GRANT;
                    w_gnt_nx[w_pick]    = 1'b1;
                    w_gnt_id_nx         = w_pick;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nx   = ST_IDLE;
                    w_gnt_nx     = '0;
                    w_gnt_id_nx  = '0;
                    w_ptr_nx     = w_ptr_after;
                    // Only flag the watchdog when it was the sole reason to let go.
                    w_timeout_nx = w_expire && !done && req[r_gnt_id];
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_gnt_nx    = '0;
                w_gnt_id_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ptr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_gnt     <= w_gnt_nx;
            r_gnt_id  <= w_gnt_id_nx;
            r_ptr     <= w_ptr_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign gnt_id    = r_gnt_id;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rr_arbiter                                                |
// | Description : Scoreboard bench for rr_arbiter against a behavioural model. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rr_arbiter;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic           done  = 1'b0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout;

    rr_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Expected {gnt, gnt_valid, gnt_id, timeout} after each sampled edge.
    typedef logic [7:0] exp_t;
    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    // Reference model: owner index (-1 when free), priority pointer, hold age.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_held  = 0;

    logic [4:0] dir_seq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt/valid/id/timeout=%b required %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [N-1:0] r, input logic d);
        exp_t e;
        bit   hit;
        logic e_to;
        req  = r;
        done = d;
        e_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (m_owner < 0 && r[i[IDW-1:0]]) begin
                    m_owner = i;
                    m_held  = 0;
                end
            end
        end else begin
            hit = TO_EN && (m_held == TIMEOUT - 1);
            if (d || !r[m_owner[IDW-1:0]] || hit) begin
                e_to    = hit && !d && r[m_owner[IDW-1:0]];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
        e[7:4] = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e[3]   = (m_owner >= 0);
        e[2:1] = (m_owner >= 0) ? m_owner[IDW-1:0] : 2'b00;
        e[0]   = e_to;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        apply(r, d);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got no expected entry, required one at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("cycle", {gnt, gnt_valid, gnt_id, timeout}, e);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", {gnt, gnt_valid, gnt_id, timeout}, 8'h00);

        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        apply('0, 1'b0);

        dir_seq = '{
            5'b0110_0, 5'b0110_0, 5'b0110_1, 5'b0110_0, 5'b0110_0, 5'b0000_0, 5'b0000_0,
            5'b1111_1, 5'b1111_1, 5'b1111_1, 5'b1111_1, 5'b1111_1, 5'b1111_1,
            5'b1111_1, 5'b1111_1, 5'b1111_1, 5'b1111_1, 5'b1111_1, 5'b1111_1,
            5'b0000_0, 5'b0000_0,
            5'b1000_0, 5'b1000_1, 5'b1001_0, 5'b1001_0, 5'b1001_1,
            5'b1001_0, 5'b1001_0, 5'b1001_1, 5'b0000_0,
            5'b0011_0, 5'b0011_0, 5'b0010_0, 5'b0010_0, 5'b0010_1, 5'b0000_0,
            5'b0100_0, 5'b0100_0, 5'b0000_1, 5'b0000_0, 5'b0000_1, 5'b0000_0
        };
        foreach (dir_seq[i]) begin
            step(dir_seq[i][4:1], dir_seq[i][0]);
        end

        // Asynchronous reset while a grant is held.
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("reset_async", {gnt, gnt_valid, gnt_id, timeout}, 8'h00);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        mon_en  = 1'b1;
        apply(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
        repeat (2)  step(4'b0000, 1'b0);
        repeat (10) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
`else
        repeat (110) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
`endif

        repeat (400) begin
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb_q.size());
        end
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
